apb_master_nslv: RTL and testbench
==================================

Name: apb_master_nslv

Overview:
Parametrised APB3 requester bridging a simple transfer/wr_rd command interface to NUM_SLV APB completers. Next generation of the current two-completer top: generic address/data widths, address-decoded PSEL vector, wait-state support, and back-to-back transfers. Adds decode-error and wait-state timeout reporting. Sits between the command source and the completer array. Completers are unchanged except for their PREADY/PSLVERR/PRDATA wiring.

Parameters:
ADDR_W, 9, PADDR/addr width
DATA_W, 8, PWDATA/PRDATA width
NUM_SLV, 2, number of completers (1..8)
SEL_LSB, 8, LSB of the slave-index field in addr; field width SW = max(1, clog2(NUM_SLV))
TIMEOUT, 15, maximum ACCESS cycles with PREADY low before abort (1..255)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
transfer  in  1  command valid
wr_rd  in  1  1=write, 0=read
addr  in  ADDR_W  command address
wr_data  in  DATA_W  write data
cmd_ready  out  1  command accepted this cycle when transfer&cmd_ready
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  1  completion error (PSLVERR, decode error or timeout); valid with rsp_valid
rd_data  out  DATA_W  read data; valid with rsp_valid for reads, else 0
PSEL  out  NUM_SLV  one-hot completer select
PENABLE  out  1  APB access phase
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  NUM_SLV*DATA_W  completer read data, slave i at [i*DATA_W +: DATA_W]
PREADY  in  NUM_SLV  completer ready
PSLVERR  in  NUM_SLV  completer error

Behaviour:
- Reset (reset=0 at clk edge): state=IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_err=0, rd_data=0, timeout counter=0. Reset mid-transfer aborts immediately, no response issued.
- idx = addr[SEL_LSB +: SW]; idx >= NUM_SLV is a decode error.
- cmd_ready = (state==IDLE) | (state==ACCESS & PREADY[cur] & ~timeout) | (state==DERR). Combinational.
- Acceptance registers PADDR=addr, PWRITE=wr_rd, PWDATA=wr_rd?wr_data:0, cur=idx.
- IDLE: accept -> SETUP (valid idx) or DERR (bad idx). No accept -> stay.
- SETUP (1 cycle): PSEL[cur]=1, PENABLE=0 -> ACCESS; counter cleared.
- ACCESS: PSEL[cur]=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable.
  - PREADY[cur]=1: next cycle rsp_valid=1, rsp_err=PSLVERR[cur], rd_data=PRDATA[cur] if read and no PSLVERR, else 0. Next state is SETUP/DERR if a new command is accepted in the same cycle (back-to-back, PSEL stays high when the same completer is selected), else IDLE with PSEL=0 and PENABLE=0.
  - PREADY[cur]=0: counter++. When counter reaches TIMEOUT: drop PSEL/PENABLE -> IDLE; next cycle rsp_valid=1, rsp_err=1, rd_data=0; no command accepted that cycle.
  - PSLVERR is sampled only when PREADY=1.
- DERR (1 cycle): no PSEL asserted; next cycle rsp_valid=1, rsp_err=1, rd_data=0. Accepting a command -> SETUP/DERR, otherwise IDLE.
- rsp_valid is a single-cycle pulse per accepted command, in acceptance order. There is no response back-pressure.
- Throughput: 0-wait back-to-back = 2 cycles/transfer; isolated transfer latency accept->rsp_valid = 3 cycles (SETUP, ACCESS, response).
- Exactly one PSEL bit is high at most; PENABLE=1 implies PSEL!=0.

Test Plan:
- Write addr=0x002 data=23 to slave0 with PREADY=1: SETUP then ACCESS with PSEL=01 and PWDATA=23; rsp_valid 3 cycles after accept, rsp_err=0.
- Write 0x105=63, then read 0x105 to slave1 with PREADY held low 3 cycles: PENABLE held 4 cycles, PADDR stable; rd_data=63, rsp_err=0.
- Six writes then six reads issued back-to-back (transfer held high): one response every 2 cycles; read data matches written values; PSEL never glitches to 0 between same-slave transfers.
- NUM_SLV=3, addr=0x300 (idx 3): no PSEL asserted; rsp_valid with rsp_err=1, rd_data=0 two cycles after accept.
- PREADY stuck low, TIMEOUT=15: abort after 15 ACCESS cycles; PSEL=0, rsp_err=1; next command is accepted normally.
- Read with PSLVERR=1 and PREADY=1: rsp_err=1, rd_data=0. Separately, drive reset=0 during ACCESS: all outputs 0 on the next edge, no rsp_valid.

Source files
------------

// File: rtl/apb_master_nslv.sv
// ----------------------------------------------------------------------------
// apb_master_nslv
//   APB3 requester that turns a transfer/wr_rd command stream into APB
//   accesses on one of NUM_SLV completers.  The completer is picked by the
//   address field addr[SEL_LSB +: SW].  The block supports wait states and
//   back-to-back transfers.  An out-of-range completer index or a wait-state
//   timeout completes with an error response.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-low reset
//   transfer, wr_rd     command valid / direction (1 = write)
//   addr, wr_data       command address and write data
//   cmd_ready           command accepted when transfer & cmd_ready
//   rsp_valid, rsp_err  one-cycle completion pulse and its error flag
//   rd_data             read data, qualified by rsp_valid, else 0
//   PSEL..PWDATA        APB requester outputs (PSEL one-hot)
//   PRDATA/PREADY/PSLVERR  completer returns, completer i at slice i
// ----------------------------------------------------------------------------
module apb_master_nslv #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 2,
    parameter int SEL_LSB = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      transfer,
    input  logic                      wr_rd,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      cmd_ready,
    output logic                      rsp_valid,
    output logic                      rsp_err,
    output logic [DATA_W-1:0]         rd_data,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DERR   = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic [7:0]        cnt_q,       cnt_d;
    logic [SW-1:0]     cur_q,       cur_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic              pwrite_q,    pwrite_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q,   rsp_err_d;
    logic [DATA_W-1:0] rd_data_q,   rd_data_d;

    logic [SW-1:0]      idx;
    logic               bad_idx;
    logic               sel_ready;
    logic               sel_err;
    logic [DATA_W-1:0]  sel_rdata;
    logic [NUM_SLV-1:0] cur_onehot;
    logic               timeout;
    logic               accept;

    assign idx     = addr[SEL_LSB +: SW];
    assign bad_idx = (32'(idx) >= NUM_SLV);

    // Return signals of the currently addressed completer
    always_comb begin
        sel_ready  = 1'b0;
        sel_err    = 1'b0;
        sel_rdata  = '0;
        cur_onehot = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (32'(cur_q) == i) begin
                sel_ready     = PREADY[i];
                sel_err       = PSLVERR[i];
                sel_rdata     = PRDATA[i*DATA_W +: DATA_W];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    // The TIMEOUT-th consecutive stalled ACCESS cycle aborts the access
    assign timeout = (state_q == ST_ACCESS) && !sel_ready && (cnt_q == 8'(TIMEOUT - 1));

    assign cmd_ready = (state_q == ST_IDLE)
                     | ((state_q == ST_ACCESS) & sel_ready & ~timeout)
                     | (state_q == ST_DERR);
    assign accept    = transfer & cmd_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_d       = cur_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rd_data_d   = '0;

        case (state_q)
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = '0;
            end
            ST_ACCESS: begin
                if (sel_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_err;
                    if (!pwrite_q && !sel_err) begin
                        rd_data_d = sel_rdata;
                    end
                end else if (timeout) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DERR: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end
            default: ;
        endcase

        // A command accepted in the completion cycle overrides the IDLE
        // return, which gives back-to-back transfers without a PSEL gap.
        if (accept) begin
            state_d  = bad_idx ? ST_DERR : ST_SETUP;
            cur_d    = idx;
            paddr_d  = addr;
            pwrite_d = wr_rd;
            pwdata_d = wr_rd ? wr_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cur_q       <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign PSEL      = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ? cur_onehot : '0;
    assign PENABLE   = (state_q == ST_ACCESS);
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_apb_master_nslv.sv
// ----------------------------------------------------------------------------
// tb_apb_master_nslv
//   Directed bench for apb_master_nslv with three completers.  Each completer
//   is a simple memory.  A shared wait-state count (wait_n) holds PREADY low
//   for the first wait_n ACCESS cycles.  Outputs are sampled on the falling
//   edge, and inputs are driven there as well.
// ----------------------------------------------------------------------------
module tb_apb_master_nslv;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int NS = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            transfer;
    logic            wr_rd;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wr_data;
    logic            cmd_ready;
    logic            rsp_valid;
    logic            rsp_err;
    logic [DW-1:0]   rd_data;
    logic [NS-1:0]   PSEL;
    logic            PENABLE;
    logic            PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic [NS*DW-1:0] PRDATA;
    logic [NS-1:0]   PREADY;
    logic [NS-1:0]   PSLVERR;

    int n_vec = 0;
    int n_err = 0;

    int   wait_n    = 0;
    logic slverr_en = 1'b0;
    logic [7:0] acc_cyc = 8'd0;
    logic [7:0] mem [0:NS-1][0:255];

    always #5 clk = ~clk;

    apb_master_nslv #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .NUM_SLV(NS),
        .SEL_LSB(8),
        .TIMEOUT(15)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .transfer (transfer),
        .wr_rd    (wr_rd),
        .addr     (addr),
        .wr_data  (wr_data),
        .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid),
        .rsp_err  (rsp_err),
        .rd_data  (rd_data),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    // Completer models
    always @(posedge clk) begin
        if (PENABLE && !(|(PREADY & PSEL))) acc_cyc <= acc_cyc + 8'd1;
        else                                acc_cyc <= 8'd0;
        for (int i = 0; i < NS; i++) begin
            if (PSEL[i] && PENABLE && PREADY[i] && PWRITE && !PSLVERR[i])
                mem[i][PADDR[7:0]] <= PWDATA;
        end
    end

    always_comb begin
        PREADY  = (int'(acc_cyc) >= wait_n) ? '1 : '0;
        PSLVERR = slverr_en ? '1 : '0;
        PRDATA  = '0;
        for (int i = 0; i < NS; i++) PRDATA[i*DW +: DW] = mem[i][PADDR[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nclk();
        @(negedge clk);
    endtask

    task automatic drive(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        transfer = 1'b1;
        wr_rd    = wr;
        addr     = a;
        wr_data  = d;
    endtask

    task automatic no_cmd();
        transfer = 1'b0;
    endtask

    // Isolated zero-wait transfer: returns response fields 3 cycles after accept
    task automatic single(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic v, output logic e, output logic [DW-1:0] r);
        drive(wr, a, d);
        nclk();
        no_cmd();
        nclk();
        nclk();
        v = rsp_valid;
        e = rsp_err;
        r = rd_data;
    endtask

    initial begin
        logic            v, e;
        logic [DW-1:0]   r;
        int              k, nr, last_cyc, glitch, en_cnt, rsp_at;
        logic            acc_pend, started;
        logic [7:0]      exp_d;

        reset = 1'b0; transfer = 1'b0; wr_rd = 1'b0; addr = '0; wr_data = '0;
        nclk(); nclk();
        // Reset state
        check("rst_psel",    32'(PSEL),      0);
        check("rst_penable", 32'(PENABLE),   0);
        check("rst_paddr",   32'(PADDR),     0);
        check("rst_pwdata",  32'(PWDATA),    0);
        check("rst_rsp",     32'(rsp_valid), 0);
        check("rst_rddata",  32'(rd_data),   0);
        check("rst_ready",   32'(cmd_ready), 1);
        reset = 1'b1;
        nclk();

        // Write 0x002 = 23 to slave0
        drive(1'b1, 10'h002, 8'd23);
        check("w1_ready", 32'(cmd_ready), 1);
        nclk(); no_cmd();
        check("w1_setup_psel", 32'(PSEL),    32'b001);
        check("w1_setup_pen",  32'(PENABLE), 0);
        check("w1_setup_data", 32'(PWDATA),  23);
        check("w1_setup_wr",   32'(PWRITE),  1);
        nclk();
        check("w1_acc_psel",   32'(PSEL),      32'b001);
        check("w1_acc_pen",    32'(PENABLE),   1);
        check("w1_acc_rsp",    32'(rsp_valid), 0);
        nclk();
        check("w1_rsp",      32'(rsp_valid), 1);
        check("w1_err",      32'(rsp_err),   0);
        check("w1_end_psel", 32'(PSEL),      0);
        check("w1_end_pen",  32'(PENABLE),   0);

        // Write 0x105 = 63, then read back with 3 wait states
        single(1'b1, 10'h105, 8'd63, v, e, r);
        check("w2_rsp", 32'(v), 1);
        check("w2_err", 32'(e), 0);
        wait_n = 3;
        drive(1'b0, 10'h105, 8'hAA);
        nclk(); no_cmd();
        check("r2_setup_psel", 32'(PSEL),   32'b010);
        check("r2_setup_wd",   32'(PWDATA), 0);
        for (int i = 0; i < 4; i++) begin
            nclk();
            check("r2_wait_pen",   32'(PENABLE),   1);
            check("r2_wait_paddr", 32'(PADDR),     32'h105);
            check("r2_wait_rsp",   32'(rsp_valid), 0);
            if (i == 0) check("r2_wait_ready", 32'(cmd_ready), 0);
        end
        nclk();
        check("r2_rsp",  32'(rsp_valid), 1);
        check("r2_data", 32'(rd_data),   63);
        check("r2_err",  32'(rsp_err),   0);
        check("r2_pen",  32'(PENABLE),   0);
        wait_n = 0;

        // Six writes then six reads back-to-back on slave0
        k = 0; nr = 0; last_cyc = 0; glitch = 0; acc_pend = 1'b0;
        for (int c = 0; c < 40; c++) begin
            nclk();
            if (acc_pend) k++;
            started = (k >= 1);
            if (started && (nr + (rsp_valid ? 1 : 0)) < 12 && PSEL !== 3'b001) glitch++;
            if (rsp_valid) begin
                exp_d = (nr < 6) ? 8'd0 : 8'((nr - 6) * 17 + 5);
                check("b2b_rddata", 32'(rd_data), 32'(exp_d));
                check("b2b_err",    32'(rsp_err), 0);
                if (nr > 0) check("b2b_spacing", 32'(c - last_cyc), 2);
                last_cyc = c;
                nr++;
            end
            if (k < 12) begin
                if (k < 6) drive(1'b1, 10'(32'h020 + k), 8'(k * 17 + 5));
                else       drive(1'b0, 10'(32'h020 + k - 6), 8'h00);
            end else begin
                no_cmd();
            end
            acc_pend = transfer && cmd_ready;
        end
        check("b2b_count",  32'(nr),     12);
        check("b2b_glitch", 32'(glitch), 0);

        // Decode error: idx 3 with three completers
        drive(1'b0, 10'h300, 8'h00);
        check("derr_ready", 32'(cmd_ready), 1);
        nclk(); no_cmd();
        check("derr_psel",  32'(PSEL),      0);
        check("derr_pen",   32'(PENABLE),   0);
        check("derr_rsp0",  32'(rsp_valid), 0);
        check("derr_cmdrdy",32'(cmd_ready), 1);
        nclk();
        check("derr_rsp", 32'(rsp_valid), 1);
        check("derr_err", 32'(rsp_err),   1);
        check("derr_rd",  32'(rd_data),   0);

        // Timeout: PREADY stuck low
        wait_n = 1000;
        drive(1'b0, 10'h005, 8'h00);
        nclk(); no_cmd();
        en_cnt = 0; rsp_at = -1;
        for (int i = 0; i < 20; i++) begin
            nclk();
            if (PENABLE) en_cnt++;
            if (rsp_valid && rsp_at < 0) begin
                rsp_at = i;
                check("to_err",  32'(rsp_err), 1);
                check("to_rd",   32'(rd_data), 0);
                check("to_psel", 32'(PSEL),    0);
            end
        end
        check("to_pen_cycles", 32'(en_cnt), 15);
        check("to_rsp_at",     32'(rsp_at), 15);
        wait_n = 0;
        single(1'b1, 10'h207, 8'h3C, v, e, r);
        check("post_to_rsp", 32'(v), 1);
        check("post_to_err", 32'(e), 0);
        single(1'b0, 10'h207, 8'h00, v, e, r);
        check("post_to_rd",  32'(r), 32'h3C);

        // PSLVERR on read
        slverr_en = 1'b1;
        single(1'b0, 10'h105, 8'h00, v, e, r);
        check("slverr_rsp", 32'(v), 1);
        check("slverr_err", 32'(e), 1);
        check("slverr_rd",  32'(r), 0);
        slverr_en = 1'b0;

        // Reset during ACCESS
        wait_n = 5;
        drive(1'b1, 10'h105, 8'h5A);
        nclk(); no_cmd();
        nclk();
        check("rsta_pen_pre", 32'(PENABLE), 1);
        reset = 1'b0;
        nclk();
        check("rsta_psel",   32'(PSEL),      0);
        check("rsta_pen",    32'(PENABLE),   0);
        check("rsta_pwrite", 32'(PWRITE),    0);
        check("rsta_paddr",  32'(PADDR),     0);
        check("rsta_pwdata", 32'(PWDATA),    0);
        check("rsta_rsp",    32'(rsp_valid), 0);
        reset = 1'b1;
        wait_n = 0;
        en_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            nclk();
            if (rsp_valid) en_cnt++;
        end
        check("rsta_no_rsp", 32'(en_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
